input_fifo_buffer: RTL and testbench
====================================

// Module: input_fifo_buffer
//
// PURPOSE
//   Parametrised successor to the single-register CPU input port. Replaces it with a DEPTH-entry FIFO.
//   - IO side: pushes words with a valid/ready handshake.
//   - CPU side: reads the head entry through the byte/halfword/word load-extract path
//     (zero- or sign-extended), then pops it explicitly.
//   - Status flags and a sticky overrun flag let software poll the port.
//   Sits between the external IO pins and the CPU load-data mux.
//
// PARAMETERS
//   DATA_WIDTH  32  word width in bits; power of two, >= 16
//   DEPTH       4   FIFO entries; power of two, >= 2
//   OFF_W       $clog2(DATA_WIDTH/8)  byte-offset width (derived, do not override)
//   CNT_W       $clog2(DEPTH)+1       occupancy width (derived, do not override)
//
// PORTS
//   clock          in   1           system clock, rising edge
//   reset          in   1           asynchronous, active-high reset
//   io_valid       in   1           IO side presents a word
//   io_ready       out  1           FIFO accepts a word (= !full)
//   io_in          in   DATA_WIDTH  IO write data
//   pop            in   1           CPU consumes the head entry
//   data_type      in   3           load type (funct3 encoding)
//   data_offset    in   OFF_W       byte offset within the head word
//   cpu_out        out  DATA_WIDTH  extracted and extended head data
//   empty          out  1           no entries
//   full           out  1           DEPTH entries
//   count          out  CNT_W       current occupancy, 0..DEPTH
//   overrun        out  1           sticky: a push was attempted while full
//   clear_overrun  in   1           clears overrun
//
// BEHAVIOUR
//   - Reset (async, immediate):
//     - wr_ptr = rd_ptr = count = 0; overrun = 0.
//     - Outputs: empty = 1, full = 0, io_ready = 1, cpu_out = 0.
//     - Storage array is not reset.
//     - Reset mid-transfer discards all entries; the first edge after reset deasserts operates normally.
//   - push = io_valid & !full. On a clock edge with push:
//     - mem[wr_ptr] <= io_in; wr_ptr advances and wraps at DEPTH.
//   - io_ready is !full from registered state only. There is no combinational path from pop to io_ready.
//     When full, a same-cycle pop does NOT admit a push.
//   - do_pop = pop & !empty. Edge: rd_ptr advances and wraps. pop while empty is ignored (no underflow).
//   - count update:
//     - +1 on push only; -1 on do_pop only.
//     - Unchanged when both occur (possible only when 0 < count < DEPTH).
//   - empty = (count == 0); full = (count == DEPTH). Both derive from registered count.
//   - Latency:
//     - A word pushed at edge N is visible on cpu_out immediately after edge N.
//     - Pop at edge N shows the next entry after edge N.
//   - cpu_out is combinational from mem[rd_ptr], data_type and data_offset. It is 0 when empty.
//   - Extraction, where B = data_offset*8:
//     - 3'b000 LB  : sign-extend head[B+7 -: 8]
//     - 3'b100 LBU : zero-extend head[B+7 -: 8]
//     - 3'b001 LH  : sign-extend head[H+15 -: 16], where H = {data_offset[OFF_W-1:1],1'b0}*8.
//       The offset LSB is ignored, so the slice never exceeds the word.
//     - 3'b101 LHU : zero-extend, same H.
//     - 3'b010 LW and all other codes : full head word, data_offset ignored.
//   - overrun:
//     - Set on any edge with io_valid & full; the word is dropped and FIFO contents are unchanged.
//     - Cleared on an edge with clear_overrun. A same-cycle set wins.
//   - Pointers are log2(DEPTH) bits, wrapping naturally. Occupancy is tracked by count, not pointer compare.
//
// STRUCTURE
//   - Package io_pkg:
//     - load_type_t enum: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
//     - Shared with the load/store unit and the output buffer.
//   - Sub-module load_extract (combinational, parameter DATA_WIDTH).
//     - Inputs: word, data_type, data_offset. Output: extended data.
//     - Reused by memory load paths.
//   - Top level holds the storage array, pointers, count, flags and handshake logic.
//
// TESTING (DATA_WIDTH=32, DEPTH=4)
//   1. Reset, then idle -> empty=1, full=0, io_ready=1, count=0, cpu_out=0, overrun=0.
//   2. Push 0x11223344, 0xAABBCCDD -> count=2.
//      - LW -> 0x11223344; LBU off=3 -> 0x00000011; LB off=0 -> 0x00000044.
//      - pop, then LH off=2 -> 0xFFFFAABB; LHU off=3 -> 0x0000AABB.
//   3. Push 5 words A..E back-to-back with io_valid held -> E is refused (io_ready=0) and overrun=1.
//      - Pops return A, B, C, D in order.
//      - clear_overrun -> overrun=0.
//   4. count=2, with push and pop in the same cycle -> count stays 2. Head advances; new word lands at the tail.
//   5. count=4, with push and pop in the same cycle -> push refused, count=3, overrun=1.
//      Also: pop while empty -> count stays 0, no pointer change.
//   6. Assert reset while count=3 -> outputs return to reset values at once, with no clock edge needed.
//      A push after reset is read back correctly.

Source files
------------

// File: rtl/io_pkg.sv
// Shared load-type encoding for the IO buffers and the load/store unit.
// Latency: none (types only).
// Backpressure: not applicable.
package io_pkg;

    // funct3 encodings of the integer load instructions
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_type_t;

endpackage

// File: rtl/load_extract.sv
// Selects a byte/halfword/word from a word and zero- or sign-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extract
    import io_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            data_type,
    input  logic [OFF_W-1:0]      data_offset,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int IDX_W = OFF_W + 3;

    logic [IDX_W-1:0] b_idx;
    logic [IDX_W-1:0] h_idx;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    // Slice the addressed byte and halfword; the halfword ignores the offset LSB
    // so it is always naturally aligned and stays inside the word.
    always_comb begin
        b_idx    = {data_offset, 3'b000};
        h_idx    = b_idx;
        h_idx[3] = 1'b0;
        byte_sel = word[b_idx +: 8];
        half_sel = word[h_idx +: 16];
    end

    // Extend according to the load type; unknown codes behave like LW.
    always_comb begin
        data = word;
        case (load_type_t'(data_type))
            LB:      data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LBU:     data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LH:      data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LHU:     data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/input_fifo_buffer.sv
// DEPTH-entry input FIFO between the IO pins and the CPU load-data mux.
// Latency: pushed word visible on cpu_out right after the push edge; pop shows next entry after its edge.
// Backpressure: io_ready = !full from registered count only; pushes while full are dropped and flag overrun.
module input_fifo_buffer
    import io_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8),
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_valid,
    output logic                  io_ready,
    input  logic [DATA_WIDTH-1:0] io_in,
    input  logic                  pop,
    input  logic [2:0]            data_type,
    input  logic [OFF_W-1:0]      data_offset,
    output logic [DATA_WIDTH-1:0] cpu_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  overrun,
    input  logic                  clear_overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] head_ext;

    // Flags come from registered occupancy so pop never reaches io_ready combinationally.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        io_ready = !full;
        push     = io_valid & !full;
        do_pop   = pop & !empty;
    end

    // Storage array is deliberately left unreset; empty masks stale contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= io_in;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is tracked separately in count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun: a push attempt while full sets it, and setting beats clearing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (io_valid && full) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_extract (
        .word        (mem[rd_ptr]),
        .data_type   (data_type),
        .data_offset (data_offset),
        .data        (head_ext)
    );

    // Present zero when there is nothing to read.
    always_comb begin
        cpu_out = empty ? '0 : head_ext;
    end

endmodule

// File: tb/tb_input_fifo_buffer.sv
module tb_input_fifo_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OFF_W = 2;
    localparam int CNT_W = 3;

    logic             clock;
    logic             reset;
    logic             io_valid;
    logic             io_ready;
    logic [DW-1:0]    io_in;
    logic             pop;
    logic [2:0]       data_type;
    logic [OFF_W-1:0] data_offset;
    logic [DW-1:0]    cpu_out;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic             clear_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of words plus the sticky flag
    logic [DW-1:0] mq[$];
    bit            m_ovr;

    logic [DW-1:0] words [5];

    input_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_valid      (io_valid),
        .io_ready      (io_ready),
        .io_in         (io_in),
        .pop           (pop),
        .data_type     (data_type),
        .data_offset   (data_offset),
        .cpu_out       (cpu_out),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_extract(input logic [DW-1:0] w, input logic [2:0] t,
                                                    input logic [1:0] off);
        logic [7:0]  by;
        logic [15:0] hw;
        int          hoff;
        by   = 8'(w >> (int'(off) * 8));
        hoff = (int'(off) / 2) * 16;
        hw   = 16'(w >> hoff);
        case (t)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'b0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'b0, hw};
            default: return w;
        endcase
    endfunction

    task automatic compare_all();
        logic [DW-1:0] exp_out;
        exp_out = (mq.size() == 0) ? '0 : model_extract(mq[0], data_type, data_offset);
        check("cyc_count",    32'(count),    32'(mq.size()));
        check("cyc_empty",    32'(empty),    32'(mq.size() == 0));
        check("cyc_full",     32'(full),     32'(mq.size() == DEPTH));
        check("cyc_io_ready", 32'(io_ready), 32'(mq.size() != DEPTH));
        check("cyc_overrun",  32'(overrun),  32'(m_ovr));
        check("cyc_cpu_out",  cpu_out,       exp_out);
    endtask

    task automatic model_update();
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (pop && !was_empty) void'(mq.pop_front());
        if (io_valid && !was_full) mq.push_back(io_in);
        if (io_valid && was_full) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
    endtask

    // One clock: compare on the falling edge, advance model at the rising edge
    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        io_valid = 1'b1;
        io_in    = w;
        step();
        io_valid = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic peek(input string name, input logic [2:0] t, input logic [1:0] off,
                        input logic [DW-1:0] exp);
        data_type   = t;
        data_offset = off;
        #1;
        check(name, cpu_out, exp);
    endtask

    initial begin
        reset = 1'b1; io_valid = 1'b0; io_in = '0; pop = 1'b0;
        data_type = 3'b010; data_offset = '0; clear_overrun = 1'b0;
        m_ovr = 1'b0;
        words[0] = 32'hA000_000A; words[1] = 32'hB000_000B; words[2] = 32'hC000_000C;
        words[3] = 32'hD000_000D; words[4] = 32'hE000_000E;

        // 1. reset state
        #12;
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_io_ready", 32'(io_ready), 32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_cpu_out",  cpu_out,       32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        step();

        // 2. extraction on a two-entry FIFO
        push_word(32'h1122_3344);
        push_word(32'hAABB_CCDD);
        check("t2_count", 32'(count), 32'd2);
        peek("t2_lw",      3'b010, 2'd0, 32'h1122_3344);
        peek("t2_lbu_o3",  3'b100, 2'd3, 32'h0000_0011);
        peek("t2_lb_o0",   3'b000, 2'd0, 32'h0000_0044);
        pop_one();
        peek("t2_lh_o2",   3'b001, 2'd2, 32'hFFFF_AABB);
        peek("t2_lhu_o3",  3'b101, 2'd3, 32'h0000_AABB);
        peek("t2_lb_o1",   3'b000, 2'd1, 32'hFFFF_FFCC);
        step();
        pop_one();
        check("t2_drained", 32'(empty), 32'd1);

        // 3. overfill with io_valid held
        data_type = 3'b010; data_offset = '0;
        io_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io_in = words[i];
            if (i == 4) check("t3_ready_full", 32'(io_ready), 32'd0);
            step();
        end
        io_valid = 1'b0;
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_count",   32'(count),   32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_pop%0d", i), cpu_out, words[i]);
            pop_one();
        end
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("t3_clear", 32'(overrun), 32'd0);

        // 4. simultaneous push and pop at count=2
        push_word(32'h0101_0101);
        push_word(32'h0202_0202);
        io_valid = 1'b1; io_in = 32'h0303_0303; pop = 1'b1;
        step();
        io_valid = 1'b0; pop = 1'b0;
        check("t4_count", 32'(count), 32'd2);
        check("t4_head",  cpu_out,    32'h0202_0202);
        pop_one();
        check("t4_tail",  cpu_out,    32'h0303_0303);
        pop_one();

        // 5. push and pop while full; then pop while empty
        for (int i = 0; i < 4; i++) push_word(words[i]);
        io_valid = 1'b1; io_in = 32'h5555_5555; pop = 1'b1;
        step();
        io_valid = 1'b0; pop = 1'b0;
        check("t5_count",   32'(count),   32'd3);
        check("t5_overrun", 32'(overrun), 32'd1);
        check("t5_head",    cpu_out,      words[1]);
        for (int i = 0; i < 3; i++) pop_one();
        pop = 1'b1;
        step();
        step();
        pop = 1'b0;
        check("t5_underflow", 32'(count), 32'd0);
        push_word(32'h6666_6666);
        check("t5_after_empty_pop", cpu_out, 32'h6666_6666);
        pop_one();

        // 6. asynchronous reset with three entries and overrun set
        for (int i = 0; i < 3; i++) push_word(words[i]);
        check("t6_pre_count", 32'(count), 32'd3);
        reset = 1'b1;
        #2;
        check("t6_empty",    32'(empty),    32'd1);
        check("t6_count",    32'(count),    32'd0);
        check("t6_io_ready", 32'(io_ready), 32'd1);
        check("t6_cpu_out",  cpu_out,       32'd0);
        check("t6_overrun",  32'(overrun),  32'd0);
        mq.delete();
        m_ovr = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        push_word(32'h7777_1234);
        check("t6_readback", cpu_out, 32'h7777_1234);
        peek("t6_lhu_o0", 3'b101, 2'd0, 32'h0000_1234);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
